// File: rtl/sounder_pkg.sv
// Shared definitions for the sounder RX averager scheduler.
// Latency: n/a (constants, state encoding and a width helper only).
// Backpressure: n/a.
package sounder_pkg;

  // Scheduler state encoding, kept as plain 2-bit constants for legacy tools.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;
  localparam logic [1:0] ST_RUN   = 2'd3;

  // Widths of the averager's M and K configuration fields.
  localparam int M_W = 8;
  localparam int K_W = 4;

  // Beat counter width: wide enough to hold N*L without truncation.
  function automatic int beat_w(input int nwidth, input int awidth);
    return nwidth + awidth;
  endfunction

endpackage

// File: rtl/sounder_beat_cnt.sv
// Loadable terminal-count beat counter with a terminal-hit flag.
// Latency: hit is combinational on the beat that reaches the terminal count.
// Backpressure: none; counts every cycle inc is high.
//
// Ports:
//   clk, rst  clock and async active-high reset
//   load      clears the count and captures term (term must be non-zero)
//   term      terminal count
//   inc       count one beat this cycle
//   hit       high when this cycle's beat makes count == term
module sounder_beat_cnt #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] term,
  input  logic         inc,
  output logic         hit
);

  logic [W-1:0] cnt;
  logic [W-1:0] term_m1;

  // term-1 is stored so the hit compare needs no adder in the flag path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      term_m1 <= '0;
    end else if (load) begin
      cnt     <= '0;
      term_m1 <= term - W'(1);
    end else if (inc) begin
      cnt     <= cnt + W'(1);
    end
  end

  assign hit = inc && (cnt == term_m1);

endmodule

// File: rtl/sounder_avg_sched.sv
// Capture scheduler for the sounder RX block averager: arm, trigger, clear, run N*L beats, done.
// Latency: start->armed 1 cycle; trig->avg_en CLR_CYC+1 cycles; final beat->done 1 cycle.
// Backpressure: none; avg_vout beats are counted only while avg_en is high.
//
// Ports:
//   clk, rst                       clock and async active-high reset
//   cfg_l/cfg_m/cfg_k/cfg_n        configuration, latched on an accepted start
//   start, stop, trig              arm, abort and timed trigger pulses
//   avg_vout                       averager output-valid beat
//   avg_en, avg_clr                averager enable and synchronous clear
//   avg_l, avg_m, avg_k            latched configuration to the averager
//   busy, armed                    status levels
//   done, aborted, err             one-cycle event pulses
//   stat_caps, stat_drops          capture / trigger-drop counters, only when
//                                  SOUNDER_AVG_SCHED_STATS_EN is defined
module sounder_avg_sched
  import sounder_pkg::*;
#(
  parameter int AWIDTH  = 10,
  parameter int NWIDTH  = 16,
  parameter int CLR_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] cfg_l,
  input  logic [M_W-1:0]    cfg_m,
  input  logic [K_W-1:0]    cfg_k,
  input  logic [NWIDTH-1:0] cfg_n,
  input  logic              start,
  input  logic              stop,
  input  logic              trig,
  input  logic              avg_vout,
  output logic              avg_en,
  output logic              avg_clr,
  output logic [AWIDTH-1:0] avg_l,
  output logic [M_W-1:0]    avg_m,
  output logic [K_W-1:0]    avg_k,
  output logic              busy,
  output logic              armed,
  output logic              done,
  output logic              aborted,
  output logic              err
`ifdef SOUNDER_AVG_SCHED_STATS_EN
  ,
  output logic [31:0]       stat_caps,
  output logic [31:0]       stat_drops
`endif
);

  localparam int BW = beat_w(NWIDTH, AWIDTH);
  localparam logic [2:0] CLR_INIT = 3'(CLR_CYC - 1);

  logic [1:0]    state;
  logic [2:0]    clr_cnt;
  logic          cfg_bad;
  logic          accept;
  logic          beat;
  logic          last_beat;
  logic [BW-1:0] nl_prod;

  assign cfg_bad = (cfg_l == '0) || (cfg_n == '0);
  // stop has priority over start even in IDLE.
  assign accept  = (state == ST_IDLE) && start && !stop && !cfg_bad;
  assign nl_prod = BW'(cfg_n) * BW'(cfg_l);

  // Status and averager controls decode straight from the state register so
  // an async reset drops avg_en and raises avg_clr without a clock edge.
  assign avg_en  = (state == ST_RUN);
  assign avg_clr = (state != ST_RUN);
  assign busy    = (state != ST_IDLE);
  assign armed   = (state == ST_ARMED);
  assign beat    = avg_vout && avg_en;

  sounder_beat_cnt #(.W(BW)) u_beat_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .term (nl_prod),
    .inc  (beat),
    .hit  (last_beat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      clr_cnt <= '0;
      avg_l   <= AWIDTH'(1);
      avg_m   <= M_W'(1);
      avg_k   <= '0;
      done    <= 1'b0;
      aborted <= 1'b0;
      err     <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      err     <= 1'b0;
      if (stop && (state != ST_IDLE)) begin
        // Abort beats every other event, including a coinciding final beat.
        state   <= ST_IDLE;
        aborted <= (state == ST_CLEAR) || (state == ST_RUN);
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !stop) begin
              if (cfg_bad) begin
                err <= 1'b1;
              end else begin
                state <= ST_ARMED;
                avg_l <= cfg_l;
                avg_m <= (cfg_m == '0) ? M_W'(1) : cfg_m;
                avg_k <= cfg_k;
              end
            end
          end
          ST_ARMED: begin
            if (trig) begin
              state   <= ST_CLEAR;
              clr_cnt <= CLR_INIT;
            end
          end
          ST_CLEAR: begin
            err <= trig;
            if (clr_cnt == '0) begin
              state <= ST_RUN;
            end else begin
              clr_cnt <= clr_cnt - 3'd1;
            end
          end
          ST_RUN: begin
            err <= trig;
            if (last_beat) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef SOUNDER_AVG_SCHED_STATS_EN
  logic cap_evt;
  logic drop_evt;

  assign cap_evt  = last_beat && !stop;
  assign drop_evt = trig && !stop && ((state == ST_CLEAR) || (state == ST_RUN));

  // Saturating counters, cleared only by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_caps  <= '0;
      stat_drops <= '0;
    end else begin
      if (cap_evt && (stat_caps != 32'hFFFF_FFFF)) begin
        stat_caps <= stat_caps + 32'd1;
      end
      if (drop_evt && (stat_drops != 32'hFFFF_FFFF)) begin
        stat_drops <= stat_drops + 32'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_sounder_avg_sched.sv
// Directed self-checking bench for sounder_avg_sched (default parameters).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// One task per scenario; each checks its own expectations inline.
module tb_sounder_avg_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  cfg_l = '0;
  logic [7:0]  cfg_m = '0;
  logic [3:0]  cfg_k = '0;
  logic [15:0] cfg_n = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        trig = 1'b0;
  logic        avg_vout = 1'b0;
  logic        avg_en, avg_clr, busy, armed, done, aborted, err;
  logic [9:0]  avg_l;
  logic [7:0]  avg_m;
  logic [3:0]  avg_k;
`ifdef SOUNDER_AVG_SCHED_STATS_EN
  logic [31:0] stat_caps, stat_drops;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sounder_avg_sched dut (
    .clk(clk), .rst(rst),
    .cfg_l(cfg_l), .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n),
    .start(start), .stop(stop), .trig(trig), .avg_vout(avg_vout),
    .avg_en(avg_en), .avg_clr(avg_clr),
    .avg_l(avg_l), .avg_m(avg_m), .avg_k(avg_k),
    .busy(busy), .armed(armed), .done(done), .aborted(aborted), .err(err)
`ifdef SOUNDER_AVG_SCHED_STATS_EN
    , .stat_caps(stat_caps), .stat_drops(stat_drops)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // Arm with the given config, trigger, and wait until the first RUN cycle.
  task automatic run_to_run(input logic [9:0] l, input logic [7:0] m,
                            input logic [3:0] k, input logic [15:0] n);
    cfg_l = l; cfg_m = m; cfg_k = k; cfg_n = n;
    start = 1'b1; step(); start = 1'b0;
    trig = 1'b1; step(); trig = 1'b0;
    step(); step();
  endtask

  task automatic test_reset();
    step(); step();
    rst = 1'b0;
    step();
    tests++; if (avg_clr !== 1'b1) begin fails++; $display("FAIL rst_clr got %b want 1", avg_clr); end
    tests++; if (avg_en !== 1'b0) begin fails++; $display("FAIL rst_en got %b want 0", avg_en); end
    tests++; if ({busy, armed, done, aborted, err} !== 5'b0) begin fails++; $display("FAIL rst_flags got %b want 00000", {busy, armed, done, aborted, err}); end
    tests++; if ({avg_l, avg_m, avg_k} !== {10'd1, 8'd1, 4'd0}) begin fails++; $display("FAIL rst_cfg got l=%0d m=%0d k=%0d want 1 1 0", avg_l, avg_m, avg_k); end
  endtask

  task automatic test_basic();
    cfg_l = 10'd4; cfg_m = 8'd3; cfg_k = 4'd1; cfg_n = 16'd2;
    start = 1'b1; step(); start = 1'b0;
    tests++; if ({armed, busy} !== 2'b11) begin fails++; $display("FAIL basic_armed got %b want 11", {armed, busy}); end
    tests++; if ({avg_l, avg_m, avg_k} !== {10'd4, 8'd3, 4'd1}) begin fails++; $display("FAIL basic_latch got l=%0d m=%0d k=%0d want 4 3 1", avg_l, avg_m, avg_k); end
    step(); step();
    tests++; if (armed !== 1'b1) begin fails++; $display("FAIL basic_wait_armed got %b want 1", armed); end
    trig = 1'b1; step(); trig = 1'b0;
    tests++; if ({avg_en, avg_clr, armed} !== 3'b010) begin fails++; $display("FAIL basic_clear1 got %b want 010", {avg_en, avg_clr, armed}); end
    avg_vout = 1'b1;  // beats during CLEAR must not be counted
    step();
    tests++; if (avg_en !== 1'b0) begin fails++; $display("FAIL basic_clear2_en got %b want 0", avg_en); end
    step();
    tests++; if ({avg_en, avg_clr} !== 2'b10) begin fails++; $display("FAIL basic_run_en got %b want 10", {avg_en, avg_clr}); end
    for (int i = 1; i <= 8; i++) begin
      avg_vout = 1'b1;
      step();
      if (i < 8) begin
        tests++; if ({done, avg_en} !== 2'b01) begin fails++; $display("FAIL basic_beat%0d got done/en %b want 01", i, {done, avg_en}); end
      end else begin
        tests++; if ({done, avg_en, avg_clr, busy} !== 4'b1010) begin fails++; $display("FAIL basic_done got %b want 1010", {done, avg_en, avg_clr, busy}); end
      end
      if (i == 4) begin
        avg_vout = 1'b0;
        step();
        tests++; if ({done, avg_en} !== 2'b01) begin fails++; $display("FAIL basic_gap got %b want 01", {done, avg_en}); end
      end
    end
    avg_vout = 1'b0;
    step();
    tests++; if ({done, avg_en} !== 2'b00) begin fails++; $display("FAIL basic_after got %b want 00", {done, avg_en}); end
  endtask

  task automatic test_illegal_cfg();
    cfg_l = 10'd0; cfg_n = 16'd2; cfg_m = 8'd3;
    start = 1'b1; step(); start = 1'b0;
    tests++; if ({err, busy} !== 2'b10) begin fails++; $display("FAIL ill_l0 got err/busy %b want 10", {err, busy}); end
    step();
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL ill_l0_pulse got %b want 0", err); end
    cfg_l = 10'd4; cfg_n = 16'd0;
    start = 1'b1; step(); start = 1'b0;
    tests++; if ({err, busy} !== 2'b10) begin fails++; $display("FAIL ill_n0 got err/busy %b want 10", {err, busy}); end
    cfg_l = 10'd5; cfg_m = 8'd0; cfg_k = 4'd3; cfg_n = 16'd1;
    start = 1'b1; step(); start = 1'b0;
    tests++; if ({avg_l, avg_m, avg_k} !== {10'd5, 8'd1, 4'd3}) begin fails++; $display("FAIL ill_m0 got l=%0d m=%0d k=%0d want 5 1 3", avg_l, avg_m, avg_k); end
    tests++; if ({armed, err} !== 2'b10) begin fails++; $display("FAIL ill_m0_armed got %b want 10", {armed, err}); end
    stop = 1'b1; step(); stop = 1'b0;
    tests++; if ({busy, aborted, avg_clr} !== 3'b001) begin fails++; $display("FAIL ill_stop_armed got %b want 001", {busy, aborted, avg_clr}); end
  endtask

  task automatic test_stop_final_beat();
    run_to_run(10'd4, 8'd3, 4'd1, 16'd2);
    avg_vout = 1'b1;
    for (int i = 0; i < 7; i++) step();
    stop = 1'b1; step(); stop = 1'b0; avg_vout = 1'b0;
    tests++; if ({aborted, done, busy, avg_clr, avg_en} !== 5'b10010) begin fails++; $display("FAIL stopfin got %b want 10010", {aborted, done, busy, avg_clr, avg_en}); end
    step();
    tests++; if ({aborted, done} !== 2'b00) begin fails++; $display("FAIL stopfin_after got %b want 00", {aborted, done}); end
  endtask

  task automatic test_trig_in_run();
    apply_reset();
    run_to_run(10'd4, 8'd3, 4'd1, 16'd2);
    avg_vout = 1'b1;
    step(); step(); step();
    trig = 1'b1; step(); trig = 1'b0;
    tests++; if ({err, avg_en} !== 2'b11) begin fails++; $display("FAIL trigrun_err got %b want 11", {err, avg_en}); end
    for (int i = 5; i <= 7; i++) begin
      step();
      tests++; if ({done, err} !== 2'b00) begin fails++; $display("FAIL trigrun_beat%0d got %b want 00", i, {done, err}); end
    end
    step(); avg_vout = 1'b0;
    tests++; if ({done, busy} !== 2'b10) begin fails++; $display("FAIL trigrun_done got %b want 10", {done, busy}); end
`ifdef SOUNDER_AVG_SCHED_STATS_EN
    tests++; if (stat_drops !== 32'd1) begin fails++; $display("FAIL stat_drops got %0d want 1", stat_drops); end
    tests++; if (stat_caps !== 32'd1) begin fails++; $display("FAIL stat_caps got %0d want 1", stat_caps); end
`endif
  endtask

  task automatic test_start_ignored();
    cfg_l = 10'd4; cfg_m = 8'd3; cfg_k = 4'd1; cfg_n = 16'd2;
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    tests++; if ({armed, busy, aborted} !== 3'b000) begin fails++; $display("FAIL startstop got %b want 000", {armed, busy, aborted}); end
    run_to_run(10'd4, 8'd3, 4'd1, 16'd2);
    avg_vout = 1'b1; step(); step();
    cfg_l = 10'd7; cfg_m = 8'd9; cfg_k = 4'd5; cfg_n = 16'd3;
    start = 1'b1; step(); start = 1'b0; avg_vout = 1'b0;
    tests++; if ({avg_l, avg_m, avg_k} !== {10'd4, 8'd3, 4'd1}) begin fails++; $display("FAIL start_busy got l=%0d m=%0d k=%0d want 4 3 1", avg_l, avg_m, avg_k); end
    tests++; if ({busy, avg_en} !== 2'b11) begin fails++; $display("FAIL start_busy_run got %b want 11", {busy, avg_en}); end
    stop = 1'b1; step(); stop = 1'b0;
    tests++; if ({aborted, busy} !== 2'b10) begin fails++; $display("FAIL start_busy_abort got %b want 10", {aborted, busy}); end
  endtask

  task automatic test_async_reset();
    run_to_run(10'd4, 8'd3, 4'd1, 16'd2);
    avg_vout = 1'b1; step(); step();
    #3 rst = 1'b1;
    #1;
    tests++; if ({avg_en, avg_clr, busy} !== 3'b010) begin fails++; $display("FAIL arst_ctl got %b want 010", {avg_en, avg_clr, busy}); end
    tests++; if ({avg_l, avg_m, avg_k} !== {10'd1, 8'd1, 4'd0}) begin fails++; $display("FAIL arst_cfg got l=%0d m=%0d k=%0d want 1 1 0", avg_l, avg_m, avg_k); end
    #1 rst = 1'b0;
    avg_vout = 1'b0;
    step();
    run_to_run(10'd2, 8'd1, 4'd0, 16'd3);
    tests++; if ({avg_l, avg_en} !== {10'd2, 1'b1}) begin fails++; $display("FAIL arst_rerun got l=%0d en=%b want 2 1", avg_l, avg_en); end
    avg_vout = 1'b1;
    for (int i = 1; i <= 5; i++) step();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL arst_early_done got %b want 0", done); end
    step(); avg_vout = 1'b0;
    tests++; if ({done, avg_en} !== 2'b10) begin fails++; $display("FAIL arst_done got %b want 10", {done, avg_en}); end
`ifdef SOUNDER_AVG_SCHED_STATS_EN
    tests++; if (stat_caps !== 32'd1) begin fails++; $display("FAIL arst_caps got %0d want 1", stat_caps); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_illegal_cfg();
    test_stop_final_beat();
    test_trig_in_run();
    test_start_ignored();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
